gus16_host_port: RTL and testbench
==================================

# gus16_host_port

Byte-wide pin-side host port for the gus16 core: the device end of the host loader protocol that the top-level testbench and bench host drive over `ui_in`/`uio_in` and read back over `uo_out`/`uio_out`. It decodes 4-phase strobe/ack byte transfers into commands that set an address, write or read 16-bit words in core memory, and halt or run the CPU. It sits between the `tt_um_gus16` pad nets and the core's memory arbiter.

## Interface
- `ADDR_W`, 12, word-address width; addresses wrap modulo 2^ADDR_W.
- `HALT_ON_RESET`, 1, reset value of `cpu_halt`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `pin_data`  in  8  host byte (from `ui_in`); held stable by host while `pin_strb`=1.
- `pin_strb`  in  1  host strobe (`uio_in[0]`), asynchronous to `clk`.
- `pin_cmd`  in  1  1 = command byte, 0 = data byte (`uio_in[1]`); stable with `pin_data`.
- `pin_out`  out  8  readback / status byte (to `uo_out`).
- `pin_ack`  out  1  device ack (`uio_out[2]`).
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  16  write data.
- `mem_we`  out  1  one-cycle write pulse.
- `mem_re`  out  1  one-cycle read-request pulse.
- `mem_rdata`  in  16  read data, valid with `mem_rvalid`.
- `mem_rvalid`  in  1  read-data valid pulse, ≥1 cycle after `mem_re`.
- `cpu_halt`  out  1  1 = core held halted.

## Operation
- `pin_strb` passes a 2-flop synchronizer → `strb_s`. Capture event E = cycle where `strb_s`=1 and previous `strb_s`=0. `pin_data`/`pin_cmd` sampled at E.
- Command byte (`pin_cmd`=1) at E from any state (except RD_WAIT) aborts the current sequence, clears partial data, then:
  - 0x01 SET_ADDR → ADDR_HI.
  - 0x02 WRITE → WR_HI.
  - 0x03 READ → pulse `mem_re` at `mem_addr` → RD_WAIT.
  - 0x04 HALT → `cpu_halt`=1, IDLE. 0x05 RUN → `cpu_halt`=0, IDLE.
  - other → `err`=1, IDLE. `err` cleared by any valid command.
- Data byte (`pin_cmd`=0) at E:
  - ADDR_HI: latch high byte → ADDR_LO. ADDR_LO: `mem_addr` = {hi,lo}[ADDR_W-1:0] → IDLE.
  - WR_HI: latch high byte → WR_LO. WR_LO: `mem_wdata`={hi,lo}, pulse `mem_we` → IDLE; `mem_addr` increments the cycle after `mem_we`.
  - RD_HI → RD_LO (host consumed high byte). RD_LO → IDLE, `mem_addr` increments.
  - IDLE: ignored, `err`=1.
- RD_WAIT: on `mem_rvalid`, latch `mem_rdata` → RD_HI. Strobe edges not captured in RD_WAIT.
- `pin_out`: RD_HI = rdata[15:8]; RD_LO = rdata[7:0]; otherwise status {`cpu_halt`, `err`, 3'b000, state[2:0]} with IDLE=0, ADDR_HI=1, ADDR_LO=2, WR_HI=3, WR_LO=4, RD_WAIT=5, RD_HI=6, RD_LO=7.

## Timing
- Reset (rst_n=0 at clk edge): state IDLE, `pin_ack`=0, `pin_out`={HALT_ON_RESET,7'b0}, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_re`=0, `cpu_halt`=HALT_ON_RESET, `err`=0, synchronizer flops 0. Reset mid-read discards a pending `mem_rvalid`.
- `pin_strb` rise → E after 2–3 clk edges. State/`mem_we`/`mem_re` update at E+1.
- `pin_ack` rises at E+1, except READ: rises the cycle after `mem_rvalid` (with RD_HI byte on `pin_out`). `pin_ack` falls the cycle after `strb_s` falls.
- 4-phase rule: host raises strb only while ack=0; ack stays 1 until strb_s=0, so no event lost or duplicated.
- `mem_we`, `mem_re` exactly one cycle each; never both.
- `pin_out` stable while `pin_ack`=1.
- Address increment at 2^ADDR_W-1 wraps to 0.

## Test plan
- Reset: hold rst_n=0 two cycles → `pin_ack`=0, `cpu_halt`=1, `pin_out`=0x80, `mem_addr`=0.
- SET_ADDR 0x01, 0x01, 0x23; WRITE 0x02, 0xBE, 0xEF → single `mem_we` with `mem_addr`=0x123, `mem_wdata`=0xBEEF; `mem_addr`=0x124 afterward.
- SET_ADDR 0x123; READ with memory model returning 0xBEEF after 3 cycles → ack delayed until rvalid+1; `pin_out`=0xBE, then 0xEF after next data handshake; `mem_addr`=0x124.
- SET_ADDR 0x0FFF, WRITE 0x1234 → write at 0xFFF, `mem_addr` wraps to 0x000.
- WRITE 0x02, 0xAA, then command 0x05 before low byte → no `mem_we`, `cpu_halt`=0, state IDLE; command 0x7F → status `err` bit set (`pin_out`=0x40).
- Assert rst_n=0 during RD_WAIT, then deliver `mem_rvalid` → stays IDLE, `pin_ack`=0, no RD_HI.

Source files
------------

// File: rtl/gus16_host_port.sv
// gus16 host port: decodes 4-phase strobe/ack byte transfers from the pad nets into
// address/write/read/halt/run commands against the core memory arbiter.
module gus16_host_port #(
  parameter int unsigned ADDR_W        = 12,
  parameter bit          HALT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pin_data,
  input  logic              pin_strb,
  input  logic              pin_cmd,
  output logic [7:0]        pin_out,
  output logic              pin_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              cpu_halt
);

  // Encodings are visible to the host in the low three status bits.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAddrHi = 3'd1,
    StAddrLo = 3'd2,
    StWrHi   = 3'd3,
    StWrLo   = 3'd4,
    StRdWait = 3'd5,
    StRdHi   = 3'd6,
    StRdLo   = 3'd7
  } state_e;

  localparam logic [7:0] CmdSetAddr = 8'h01;
  localparam logic [7:0] CmdWrite   = 8'h02;
  localparam logic [7:0] CmdRead    = 8'h03;
  localparam logic [7:0] CmdHalt    = 8'h04;
  localparam logic [7:0] CmdRun     = 8'h05;

  logic              strb_meta_q, strb_s_q, strb_prev_q;
  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              ack_q, ack_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              capture;
  logic [15:0]       addr_full;

  // Two-flop synchronizer for the asynchronous strobe, plus edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strb_meta_q <= 1'b0;
      strb_s_q    <= 1'b0;
      strb_prev_q <= 1'b0;
    end else begin
      strb_meta_q <= pin_strb;
      strb_s_q    <= strb_meta_q;
      strb_prev_q <= strb_s_q;
    end
  end

  // Rising edge of the synchronized strobe; ignored while a read is outstanding.
  assign capture   = strb_s_q & ~strb_prev_q & (state_q != StRdWait);
  // pin_data is held stable by the host while the strobe is high, so it is safe to use at E.
  assign addr_full = {hi_q, pin_data};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hi_q    <= 8'h00;
      rdata_q <= 16'h0000;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      ack_q   <= 1'b0;
      halt_q  <= HALT_ON_RESET;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      ack_q   <= ack_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // Command decode, byte sequencing and handshake next-state.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    ack_d   = ack_q;
    halt_d  = halt_q;
    err_d   = err_q;

    // Post-write increment: the address stays put for the cycle mem_we is high.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (!strb_s_q) begin
      ack_d = 1'b0;
    end

    if (state_q == StRdWait && mem_rvalid) begin
      rdata_d = mem_rdata;
      state_d = StRdHi;
      ack_d   = 1'b1;
    end

    if (capture) begin
      if (pin_cmd) begin
        // Any command aborts the sequence in flight.
        hi_d    = 8'h00;
        err_d   = 1'b0;
        ack_d   = 1'b1;
        state_d = StIdle;
        case (pin_data)
          CmdSetAddr: state_d = StAddrHi;
          CmdWrite:   state_d = StWrHi;
          CmdRead: begin
            re_d    = 1'b1;
            ack_d   = 1'b0;  // ack waits for the read data
            state_d = StRdWait;
          end
          CmdHalt:    halt_d = 1'b1;
          CmdRun:     halt_d = 1'b0;
          default:    err_d  = 1'b1;
        endcase
      end else begin
        ack_d = 1'b1;
        case (state_q)
          StAddrHi: begin
            hi_d    = pin_data;
            state_d = StAddrLo;
          end
          StAddrLo: begin
            addr_d  = addr_full[ADDR_W-1:0];
            hi_d    = 8'h00;
            state_d = StIdle;
          end
          StWrHi: begin
            hi_d    = pin_data;
            state_d = StWrLo;
          end
          StWrLo: begin
            wdata_d = addr_full;
            we_d    = 1'b1;
            hi_d    = 8'h00;
            state_d = StIdle;
          end
          StRdHi: state_d = StRdLo;
          StRdLo: begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StIdle;
          end
          default: err_d = 1'b1;  // data byte with no sequence open
        endcase
      end
    end
  end

  // Readback byte while a read is being drained, otherwise the status byte.
  always_comb begin
    pin_out = {halt_q, err_q, 3'b000, state_q};
    case (state_q)
      StRdHi:  pin_out = rdata_q[15:8];
      StRdLo:  pin_out = rdata_q[7:0];
      default: pin_out = {halt_q, err_q, 3'b000, state_q};
    endcase
  end

  assign pin_ack   = ack_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign cpu_halt  = halt_q;

endmodule

// File: tb/tb_gus16_host_port.sv
// Scoreboard bench for gus16_host_port: host handshakes push expectations, a negedge
// monitor pops and compares on every ack rise, write pulse and read pulse.
module tb_gus16_host_port;

  localparam int unsigned AW = 12;

  typedef struct {
    logic [7:0] out;
    bit         is_read;
  } ack_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    pin_data;
  logic          pin_strb;
  logic          pin_cmd;
  logic [7:0]    pin_out;
  logic          pin_ack;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [15:0]   mem_rdata;
  logic          mem_rvalid;
  logic          cpu_halt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rv_cnt = 0;
  int rv_cyc = 0;
  logic [15:0] rd_value;
  logic        ack_prev = 1'b0;

  ack_exp_t          exp_ack[$];
  logic [AW+15:0]    exp_we[$];
  logic [AW-1:0]     exp_re[$];

  gus16_host_port #(
    .ADDR_W       (AW),
    .HALT_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin_data  (pin_data),
    .pin_strb  (pin_strb),
    .pin_cmd   (pin_cmd),
    .pin_out   (pin_out),
    .pin_ack   (pin_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .cpu_halt  (cpu_halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor plus memory responder (read data three cycles after mem_re).
  always @(negedge clk) begin
    ack_exp_t e;
    logic [AW+15:0] w;
    logic [AW-1:0]  r;
    if (rv_cnt != 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_value;
        rv_cyc     = cyc;
      end
    end else begin
      mem_rvalid = 1'b0;
    end

    if (pin_ack === 1'b1 && ack_prev === 1'b0) begin
      if (exp_ack.size() == 0) flag("unexpected_ack");
      else begin
        e = exp_ack.pop_front();
        check("pin_out_at_ack", {24'h0, pin_out}, {24'h0, e.out});
        if (e.is_read) check("read_ack_latency", cyc - rv_cyc, 1);
      end
    end
    ack_prev = pin_ack;

    if (mem_we === 1'b1) begin
      if (exp_we.size() == 0) flag("unexpected_mem_we");
      else begin
        w = exp_we.pop_front();
        check("mem_we_addr_data", {4'h0, mem_addr, mem_wdata}, {4'h0, w});
      end
    end

    if (mem_re === 1'b1) begin
      rv_cnt = 3;
      if (exp_re.size() == 0) flag("unexpected_mem_re");
      else begin
        r = exp_re.pop_front();
        check("mem_re_addr", {20'h0, mem_addr}, {20'h0, r});
      end
    end

    if (mem_we === 1'b1 && mem_re === 1'b1) flag("we_and_re_together");
  end

  task automatic wait_ack(input logic val, input string name);
    int n = 0;
    while (pin_ack !== val && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, pin_ack}, {31'h0, val});
  endtask

  // One 4-phase byte transfer; the expected pin_out at ack is queued first.
  task automatic xfer(input bit cmd, input logic [7:0] data, input logic [7:0] exp_out,
                      input bit is_read);
    ack_exp_t e;
    e.out     = exp_out;
    e.is_read = is_read;
    exp_ack.push_back(e);
    wait_ack(1'b0, "ack_idle_before_strb");
    pin_data = data;
    pin_cmd  = cmd;
    pin_strb = 1'b1;
    wait_ack(1'b1, "ack_rise_timeout");
    pin_strb = 1'b0;
    wait_ack(1'b0, "ack_fall_timeout");
  endtask

  task automatic set_addr(input logic [15:0] a);
    xfer(1'b1, 8'h01, 8'h81, 1'b0);
    xfer(1'b0, a[15:8], 8'h82, 1'b0);
    xfer(1'b0, a[7:0], 8'h80, 1'b0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    pin_strb   = 1'b0;
    pin_cmd    = 1'b0;
    pin_data   = 8'h00;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    rd_value   = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ack", {31'h0, pin_ack}, 0);
    check("reset_halt", {31'h0, cpu_halt}, 1);
    check("reset_pin_out", {24'h0, pin_out}, 32'h80);
    check("reset_mem_addr", {20'h0, mem_addr}, 0);
    check("reset_we_re", {30'h0, mem_we, mem_re}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Address set then one word write, address post-increments
    set_addr(16'h0123);
    check("addr_after_set", {20'h0, mem_addr}, 32'h123);
    exp_we.push_back({12'h123, 16'hBEEF});
    xfer(1'b1, 8'h02, 8'h83, 1'b0);
    xfer(1'b0, 8'hBE, 8'h84, 1'b0);
    xfer(1'b0, 8'hEF, 8'h80, 1'b0);
    check("addr_after_write", {20'h0, mem_addr}, 32'h124);

    // Read back: ack waits for rvalid, high byte then low byte
    set_addr(16'h0123);
    rd_value = 16'hBEEF;
    exp_re.push_back(12'h123);
    xfer(1'b1, 8'h03, 8'hBE, 1'b1);
    xfer(1'b0, 8'h00, 8'hEF, 1'b0);
    xfer(1'b0, 8'h00, 8'h80, 1'b0);
    check("addr_after_read", {20'h0, mem_addr}, 32'h124);

    // Write at top of address space wraps
    set_addr(16'h0FFF);
    exp_we.push_back({12'hFFF, 16'h1234});
    xfer(1'b1, 8'h02, 8'h83, 1'b0);
    xfer(1'b0, 8'h12, 8'h84, 1'b0);
    xfer(1'b0, 8'h34, 8'h80, 1'b0);
    check("addr_wrap", {20'h0, mem_addr}, 0);

    // Abort a write with RUN, then error paths and error clear
    xfer(1'b1, 8'h02, 8'h83, 1'b0);
    xfer(1'b0, 8'hAA, 8'h84, 1'b0);
    xfer(1'b1, 8'h05, 8'h00, 1'b0);
    check("run_clears_halt", {31'h0, cpu_halt}, 0);
    xfer(1'b1, 8'h7F, 8'h40, 1'b0);
    xfer(1'b0, 8'h55, 8'h40, 1'b0);
    xfer(1'b1, 8'h04, 8'h80, 1'b0);
    check("halt_sets_halt", {31'h0, cpu_halt}, 1);
    check("addr_unchanged_by_abort", {20'h0, mem_addr}, 0);

    // Reset while a read is outstanding; late rvalid must be ignored
    rd_value = 16'hDEAD;
    exp_re.push_back(12'h000);
    pin_cmd  = 1'b1;
    pin_data = 8'h03;
    pin_strb = 1'b1;
    n = 0;
    while (mem_re !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rd_abort_re_seen", {31'h0, mem_re}, 1);
    rst_n    = 1'b0;
    pin_strb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rd_abort_ack", {31'h0, pin_ack}, 0);
    check("rd_abort_pin_out", {24'h0, pin_out}, 32'h80);
    check("rd_abort_halt", {31'h0, cpu_halt}, 1);

    check("ack_queue_drained", exp_ack.size(), 0);
    check("we_queue_drained", exp_we.size(), 0);
    check("re_queue_drained", exp_re.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
